// File: rtl/seg_fade_pkg.sv
// Shared types and constants for the segment fade/PWM output stage.
// Gamma LUT and mapping function exist only when SEG_FADE_GAMMA_EN is defined.
package seg_fade_pkg;

    localparam int LEVEL_W_DFLT = 4;
    localparam int MAX_LEVEL    = (32'd1 << LEVEL_W_DFLT) - 32'd1;

    typedef logic [LEVEL_W_DFLT-1:0] level_t;

`ifdef SEG_FADE_GAMMA_EN
    // Perceptual brightness curve: dim levels are compressed toward dark.
    localparam level_t GAMMA [16] = '{
        4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3,
        4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd11, 4'd13, 4'd15
    };

    function automatic level_t gamma_map(input level_t lvl);
        return GAMMA[lvl];
    endfunction
`endif

endpackage

// File: rtl/seg_fade_pwm_if.sv
// Segment drive bus between the snake animator side and the fade/PWM stage.
interface seg_fade_pwm_if #(parameter int NSEG = 8);

    logic [NSEG-1:0] seg_in;
    logic [3:0]      decay_sel;
    logic            bypass;
    logic [NSEG-1:0] seg_out;
    logic            frame_tick;

    modport master (
        output seg_in, decay_sel, bypass,
        input  seg_out, frame_tick
    );

    modport slave (
        input  seg_in, decay_sel, bypass,
        output seg_out, frame_tick
    );

endinterface

// File: rtl/seg_fade_channel.sv
// One segment channel: brightness level with snap-on / step-down fade and PWM output flop.
// Optional gamma mapping of the level when SEG_FADE_GAMMA_EN is defined.
module seg_fade_channel
    import seg_fade_pkg::*;
#(
    parameter int LEVEL_W = LEVEL_W_DFLT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               seg_i,
    input  logic               decay_step_i,
    input  logic [LEVEL_W-1:0] pwm_cnt_i,
    input  logic               bypass_i,
    output logic               seg_out_o
);

    localparam logic [LEVEL_W-1:0] LVL_MAX  = {LEVEL_W{1'b1}};
    localparam logic [LEVEL_W-1:0] LVL_ZERO = {LEVEL_W{1'b0}};
    localparam logic [LEVEL_W-1:0] LVL_ONE  = {{(LEVEL_W-1){1'b0}}, 1'b1};

    logic [LEVEL_W-1:0] level_q, level_d;
    logic [LEVEL_W-1:0] eff_level_s;
    logic               out_q, out_d;

    // Level update: an active segment beats a decay step in the same cycle.
    always_comb begin
        level_d = level_q;
        if (seg_i) begin
            level_d = LVL_MAX;
        end else if (decay_step_i && (level_q != LVL_ZERO)) begin
            level_d = level_q - LVL_ONE;
        end else begin
            level_d = level_q;
        end
    end

`ifdef SEG_FADE_GAMMA_EN
    if (LEVEL_W != 4) begin : g_gamma_width_chk
        $error("seg_fade_channel: gamma LUT requires LEVEL_W == 4");
    end

    always_comb begin
        eff_level_s = LEVEL_W'(gamma_map(level_t'(level_q)));
    end
`else
    always_comb begin
        eff_level_s = level_q;
    end
`endif

    // Bypass samples the raw registered segment so latency matches PWM mode's output flop.
    always_comb begin
        out_d = 1'b0;
        if (bypass_i) begin
            out_d = seg_i;
        end else begin
            out_d = (pwm_cnt_i < eff_level_s);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= LVL_ZERO;
            out_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            out_q   <= out_d;
        end
    end

    assign seg_out_o = out_q;

endmodule

// File: rtl/seg_fade_pwm.sv
// Segment output stage: per-segment PWM brightness with a fading trail after turn-off.
// Build option: define SEG_FADE_GAMMA_EN to apply a gamma curve to the brightness levels.
module seg_fade_pwm
    import seg_fade_pkg::*;
#(
    parameter int NSEG        = 8,
    parameter int LEVEL_W     = LEVEL_W_DFLT,
    parameter int FRAME_CNT_W = 15
) (
    input  logic          clk,
    input  logic          rst,
    seg_fade_pwm_if.slave seg_bus
);

    localparam logic [LEVEL_W-1:0]     PWM_LAST  = {{(LEVEL_W-1){1'b1}}, 1'b0};
    localparam logic [LEVEL_W-1:0]     PWM_ONE   = {{(LEVEL_W-1){1'b0}}, 1'b1};
    localparam logic [FRAME_CNT_W-1:0] FRAME_ONE = {{(FRAME_CNT_W-1){1'b0}}, 1'b1};

    logic [NSEG-1:0]        seg_q, seg_d;
    logic [LEVEL_W-1:0]     pwm_cnt_q, pwm_cnt_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   frame_tick_q, frame_tick_d;
    logic [FRAME_CNT_W-1:0] decay_mask_s;
    int                     sel_sat_s;
    logic                   decay_step_s;
    logic [NSEG-1:0]        seg_out_s;

    // PWM period is MAX cycles; the tick marks the first cycle of each new frame.
    always_comb begin
        seg_d        = seg_bus.seg_in;
        pwm_cnt_d    = pwm_cnt_q;
        frame_tick_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        if (pwm_cnt_q == PWM_LAST) begin
            pwm_cnt_d    = {LEVEL_W{1'b0}};
            frame_tick_d = 1'b1;
        end else begin
            pwm_cnt_d    = pwm_cnt_q + PWM_ONE;
            frame_tick_d = 1'b0;
        end
        if (frame_tick_q) begin
            frame_cnt_d = frame_cnt_q + FRAME_ONE;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Prescaler: step when the low decay_sel bits of the frame count are all zero.
    always_comb begin
        sel_sat_s    = 0;
        decay_mask_s = {FRAME_CNT_W{1'b0}};
        if (int'(seg_bus.decay_sel) > FRAME_CNT_W) begin
            sel_sat_s = FRAME_CNT_W;
        end else begin
            sel_sat_s = int'(seg_bus.decay_sel);
        end
        for (int i = 0; i < FRAME_CNT_W; i++) begin
            decay_mask_s[i] = (i < sel_sat_s);
        end
        decay_step_s = frame_tick_q &&
                       ((frame_cnt_q & decay_mask_s) == {FRAME_CNT_W{1'b0}});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q        <= {NSEG{1'b0}};
            pwm_cnt_q    <= {LEVEL_W{1'b0}};
            frame_cnt_q  <= {FRAME_CNT_W{1'b0}};
            frame_tick_q <= 1'b0;
        end else begin
            seg_q        <= seg_d;
            pwm_cnt_q    <= pwm_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    for (genvar i = 0; i < NSEG; i++) begin : g_ch
        seg_fade_channel #(
            .LEVEL_W (LEVEL_W)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .seg_i        (seg_q[i]),
            .decay_step_i (decay_step_s),
            .pwm_cnt_i    (pwm_cnt_q),
            .bypass_i     (seg_bus.bypass),
            .seg_out_o    (seg_out_s[i])
        );
    end

    assign seg_bus.seg_out    = seg_out_s;
    assign seg_bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_fade_pwm.sv
// Directed bench for seg_fade_pwm: reset, full-on, linear and slow fade, re-assert priority, bypass.
module tb_seg_fade_pwm;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    seg_fade_pwm_if #(.NSEG(8)) seg_bus ();

    seg_fade_pwm #(
        .NSEG        (8),
        .LEVEL_W     (4),
        .FRAME_CNT_W (15)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .seg_bus (seg_bus)
    );

    always #5 clk = ~clk;

    task automatic wait_tick();
        int n = 0;
        @(negedge clk);
        while (seg_bus.frame_tick !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (seg_bus.frame_tick !== 1'b1) begin
            checks++; errors++;
            $display("FAIL wait_tick: frame_tick=%b after 40 cycles, expected 1", seg_bus.frame_tick);
        end
    endtask

    task automatic count_window(input int ch, output int highs);
        highs = 0;
        repeat (15) begin
            @(negedge clk);
            if (seg_bus.seg_out[ch] === 1'b1) highs++;
        end
    endtask

    // Called right after rst is released: first tick 15 cycles later, all outputs dark.
    task automatic check_release_tick(input string tag);
        int first = -1;
        int lit   = 0;
        for (int c = 0; c <= 20; c++) begin
            @(negedge clk);
            if (seg_bus.frame_tick === 1'b1 && first < 0) first = c;
            if (seg_bus.seg_out !== 8'h00) lit++;
        end
        checks++;
        if (first !== 15) begin
            errors++;
            $display("FAIL %s first_tick: got cycle %0d expected 15", tag, first);
        end
        checks++;
        if (lit !== 0) begin
            errors++;
            $display("FAIL %s dark_after_reset: got %0d lit cycles expected 0", tag, lit);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        seg_bus.seg_in = 8'h00; seg_bus.decay_sel = 4'd0; seg_bus.bypass = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (seg_bus.seg_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_seg_out: got %h expected 00", seg_bus.seg_out);
        end
        checks++;
        if (seg_bus.frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_frame_tick: got %b expected 0", seg_bus.frame_tick);
        end
        @(posedge clk); #1 rst = 1'b0;
        check_release_tick("reset");
    endtask

    task automatic test_full_on();
        int bad = 0;
        @(posedge clk); #1 seg_bus.seg_in = 8'h01;
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            if (c == 2) begin
                checks++;
                if (seg_bus.seg_out !== 8'h00) begin
                    errors++;
                    $display("FAIL full_on_latency: got %h expected 00 at cycle 2", seg_bus.seg_out);
                end
            end
            if (c >= 3 && seg_bus.seg_out !== 8'h01) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL full_on_steady: got %0d wrong cycles expected 0", bad);
        end
    endtask

    task automatic test_linear_fade();
        int highs;
        seg_bus.decay_sel = 4'd0;
        wait_tick();
        @(posedge clk); #1 seg_bus.seg_in = 8'h00;
        wait_tick();
        @(negedge clk);
        for (int k = 1; k <= 17; k++) begin
            count_window(0, highs);
            checks++;
            if (highs !== ((k < 15) ? 15 - k : 0)) begin
                errors++;
                $display("FAIL linear_frame%0d: got %0d high cycles expected %0d",
                         k, highs, (k < 15) ? 15 - k : 0);
            end
        end
    endtask

    task automatic test_slow_decay();
        int hist [16];
        int highs;
        foreach (hist[i]) hist[i] = 0;
        seg_bus.decay_sel = 4'd3;
        @(posedge clk); #1 seg_bus.seg_in = 8'h01;
        repeat (20) @(posedge clk);
        wait_tick();
        @(posedge clk); #1 seg_bus.seg_in = 8'h00;
        @(negedge clk);
        for (int w = 0; w < 128; w++) begin
            count_window(0, highs);
            hist[highs]++;
        end
        checks++;
        if (hist[15] < 1 || hist[15] > 8) begin
            errors++;
            $display("FAIL slow_hold15: got %0d frames expected 1..8", hist[15]);
        end
        for (int h = 1; h <= 14; h++) begin
            checks++;
            if (hist[h] !== 8) begin
                errors++;
                $display("FAIL slow_level%0d: got %0d frames expected 8", h, hist[h]);
            end
        end
        checks++;
        if (hist[0] < 8) begin
            errors++;
            $display("FAIL slow_dark: got %0d dark frames expected >= 8", hist[0]);
        end
    endtask

    task automatic test_reassert();
        int cnt5  = 0;
        int cnt15 = 0;
        seg_bus.decay_sel = 4'd0;
        @(posedge clk); #1 seg_bus.seg_in = 8'h04;
        repeat (20) @(posedge clk);
        wait_tick();
        for (int c = 1; c <= 181; c++) begin
            @(posedge clk); #1;
            seg_bus.seg_in = (c == 164) ? 8'h04 : 8'h00;
            @(negedge clk);
            if (c == 165) begin
                checks++;
                if (seg_bus.frame_tick !== 1'b1) begin
                    errors++;
                    $display("FAIL reassert_tick_align: got %b expected 1", seg_bus.frame_tick);
                end
            end
            if (c >= 152 && c <= 166 && seg_bus.seg_out[2] === 1'b1) cnt5++;
            if (c >= 167 && c <= 181 && seg_bus.seg_out[2] === 1'b1) cnt15++;
        end
        checks++;
        if (cnt5 !== 5) begin
            errors++;
            $display("FAIL reassert_pre_level: got %0d high cycles expected 5", cnt5);
        end
        checks++;
        if (cnt15 !== 15) begin
            errors++;
            $display("FAIL reassert_priority: got %0d high cycles expected 15", cnt15);
        end
    endtask

    task automatic test_bypass();
        logic [7:0] h0, h1, h2, v;
        int full = 0;
        int highs;
        @(posedge clk); #1 seg_bus.bypass = 1'b1; seg_bus.seg_in = 8'hAA;
        repeat (3) @(posedge clk);
        h0 = 8'hAA; h1 = 8'hAA; h2 = 8'hAA;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            v = (c % 2 == 0) ? 8'h55 : 8'hAA;
            seg_bus.seg_in = v;
            h2 = h1; h1 = h0; h0 = v;
            @(negedge clk);
            checks++;
            if (seg_bus.seg_out !== h2) begin
                errors++;
                $display("FAIL bypass_cycle%0d: got %h expected %h", c, seg_bus.seg_out, h2);
            end
        end
        @(posedge clk); #1 seg_bus.seg_in = 8'hFF;
        repeat (3) @(posedge clk);
        wait_tick();
        @(posedge clk); #1 seg_bus.bypass = 1'b0; seg_bus.seg_in = 8'h00;
        @(negedge clk);
        checks++;
        if (seg_bus.seg_out !== 8'hFF) begin
            errors++;
            $display("FAIL bypass_release_edge: got %h expected ff", seg_bus.seg_out);
        end
        repeat (15) begin
            @(negedge clk);
            if (seg_bus.seg_out === 8'hFF) full++;
        end
        checks++;
        if (full !== 15) begin
            errors++;
            $display("FAIL bypass_release_full: got %0d full cycles expected 15", full);
        end
        count_window(3, highs);
        checks++;
        if (highs !== 14) begin
            errors++;
            $display("FAIL bypass_release_fade: got %0d high cycles expected 14", highs);
        end
    endtask

    task automatic test_reset_mid_fade();
        int cnt8 = 0;
        seg_bus.decay_sel = 4'd0;
        @(posedge clk); #1 seg_bus.seg_in = 8'h01;
        repeat (20) @(posedge clk);
        wait_tick();
        for (int c = 1; c <= 122; c++) begin
            @(posedge clk); #1;
            if (c == 1) seg_bus.seg_in = 8'h00;
            if (c == 122) rst = 1'b1;
            @(negedge clk);
            if (c >= 107 && c <= 121 && seg_bus.seg_out[0] === 1'b1) cnt8++;
        end
        checks++;
        if (cnt8 !== 8) begin
            errors++;
            $display("FAIL midfade_level: got %0d high cycles expected 8", cnt8);
        end
        @(posedge clk); #1 rst = 1'b0;
        check_release_tick("midfade_reset");
    endtask

    initial begin
        test_reset();
        test_full_on();
        test_linear_fade();
        test_slow_decay();
        test_reassert();
        test_bypass();
        test_reset_mid_fade();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
